// File: rtl/invaders_memmap_if.sv
// invaders_memmap bus bundle: CPU, downloader, video, colour and hiscore
// signals; master drives requests, slave is the memory subsystem.
interface invaders_memmap_if #(
  parameter int RAM_AW  = 13,
  parameter int CRAM_AW = 11
);
  logic [15:0]        cpu_addr;
  logic               cpu_wr;
  logic [7:0]         cpu_din;
  logic [7:0]         cpu_dout;
  logic               cpu_hold;
  logic [2:0]         cmode;
  logic [15:0]        dn_addr;
  logic [7:0]         dn_data;
  logic               dn_wr;
  logic [RAM_AW-1:0]  vid_addr;
  logic               vid_blank;
  logic [7:0]         vid_data;
  logic [CRAM_AW-1:0] color_addr;
  logic [7:0]         color_out;
  logic               hs_req;
  logic               hs_we;
  logic [RAM_AW-1:0]  hs_addr;
  logic [7:0]         hs_din;
  logic [7:0]         hs_dout;
  logic               hs_ack;

  modport master (
    output cpu_addr, cpu_wr, cpu_din, cmode,
    output dn_addr, dn_data, dn_wr,
    output vid_addr, vid_blank, color_addr,
    output hs_req, hs_we, hs_addr, hs_din,
    input  cpu_dout, cpu_hold, vid_data,
    input  color_out, hs_dout, hs_ack
  );

  modport slave (
    input  cpu_addr, cpu_wr, cpu_din, cmode,
    input  dn_addr, dn_data, dn_wr,
    input  vid_addr, vid_blank, color_addr,
    input  hs_req, hs_we, hs_addr, hs_din,
    output cpu_dout, cpu_hold, vid_data,
    output color_out, hs_dout, hs_ack
  );
endinterface

// File: rtl/invaders_memmap.sv
// 8080 arcade memory subsystem: ROM banks, work RAM, colour store, port-B
// arbiter. Define INVADERS_RAM_CLEAR_EN for the post-reset work-RAM sweep.
module invaders_memmap #(
  parameter int ROM_BANKS = 2,
  parameter int RAM_AW    = 13,
  parameter int CRAM_AW   = 11,
  parameter int PREFETCH  = 1
) (
  input logic               clk,
  input logic               rst,
  invaders_memmap_if.slave  bus
);
  localparam int ROM_AW = 13 + $clog2(ROM_BANKS);
  localparam logic [2:0] NB = 3'(ROM_BANKS);
  localparam logic [4:0] CPROM_SEL = 5'(4 * ROM_BANKS);

  typedef enum logic [1:0] {
    RUN_VID,
    HS_GRANT,
    CLEAR
  } state_t;

  logic [7:0] rom  [ROM_BANKS*8192];
  logic [7:0] ram  [2**RAM_AW];
  logic [7:0] cram [2**CRAM_AW];

  state_t state;
  logic [7:0] cpu_dout_q, color_q;
  logic [7:0] vid_q, hs_dout_q;
  logic hs_ack_q;
  logic hold;
  logic clearing;

  logic [2:0] cpu_reg, cpu_bank;
  logic win1, win23, cwin;
  logic ram_hit, rom_hit;
  logic [10:0] cwin_a11;
  logic [CRAM_AW-1:0] cwin_a, dn_cram_a;
  logic [ROM_AW-1:0] cpu_rom_a, dn_rom_a;
  logic [RAM_AW-1:0] pa_addr, vid_rd_a;
  logic pa_we, pb_we;
  logic dn_rom_we, dn_cram_we, cpu_cram_we;
  logic [7:0] pa_din, cpu_rd;
  logic [7:0] color_raw, color_swz;

  assign cpu_reg = bus.cpu_addr[15:13];
  assign win1 = bus.cmode == 3'd1 &&
                bus.cpu_addr[15:10] == 6'b010111;
  assign win23 = (bus.cmode == 3'd2 ||
                  bus.cmode == 3'd3) &&
                 cpu_reg == 3'd6;
  assign cwin = win1 | win23;
  assign cwin_a11 = win1 ?
    {1'b0, bus.cpu_addr[9:0]} :
    {bus.cpu_addr[13:8], bus.cpu_addr[4:0]};
  assign cwin_a = CRAM_AW'(cwin_a11);

  assign ram_hit = cpu_reg == 3'd1;
  assign cpu_bank = (cpu_reg == 3'd0) ?
    3'd0 : cpu_reg - 3'd1;
  assign rom_hit = !cwin &&
    (cpu_reg == 3'd0 ||
     (cpu_reg >= 3'd2 && cpu_bank < NB));
  assign cpu_rom_a =
    ROM_AW'({cpu_bank[1:0], bus.cpu_addr[12:0]});

  assign dn_rom_we = bus.dn_wr &&
    bus.dn_addr[15:13] < NB;
  assign dn_rom_a = ROM_AW'(bus.dn_addr[14:0]);
  assign dn_cram_we = bus.dn_wr &&
    bus.dn_addr[15:11] == CPROM_SEL;
  assign dn_cram_a = CRAM_AW'(bus.dn_addr[10:0]);
  assign cpu_cram_we = bus.cpu_wr && cwin &&
    !hold && !dn_cram_we;

`ifdef INVADERS_RAM_CLEAR_EN
  logic [RAM_AW-1:0] clr_addr;
  assign clearing = state == CLEAR;
  assign pa_addr = clearing ?
    clr_addr : bus.cpu_addr[RAM_AW-1:0];
`else
  assign clearing = 1'b0;
  assign hold = 1'b0;
  assign pa_addr = bus.cpu_addr[RAM_AW-1:0];
`endif

  assign pa_we = clearing ||
    (bus.cpu_wr && ram_hit && !hold);
  assign pa_din = clearing ? 8'h00 : bus.cpu_din;
  assign pb_we = state == HS_GRANT && bus.hs_we;
  assign vid_rd_a = bus.vid_addr + RAM_AW'(PREFETCH);

  // CPU read decode; window outranks ROM bank 1 in mode 1
  always_comb begin
    cpu_rd = 8'h00;
    unique case (1'b1)
      cwin:    cpu_rd = cram[cwin_a];
      ram_hit: cpu_rd = ram[bus.cpu_addr[RAM_AW-1:0]];
      rom_hit: cpu_rd = rom[cpu_rom_a];
      default: cpu_rd = 8'h00;
    endcase
  end

  // colour output swizzle selected by cmode
  always_comb begin
    color_raw = cram[bus.color_addr];
    case (bus.cmode)
      3'd3: color_swz = ~color_raw;
      3'd4: color_swz = {color_raw[7:3], color_raw[1],
                         color_raw[2], color_raw[0]};
      default: color_swz = color_raw;
    endcase
  end

  // ROM and colour store writes; contents survive reset
  always_ff @(posedge clk) begin
    if (dn_rom_we) rom[dn_rom_a] <= bus.dn_data;
    if (dn_cram_we) cram[dn_cram_a] <= bus.dn_data;
    if (cpu_cram_we) cram[cwin_a] <= bus.cpu_din;
  end

  // work RAM writes; port B last so hiscore wins a collision
  always_ff @(posedge clk) begin
    if (pa_we) ram[pa_addr] <= pa_din;
    if (pb_we) ram[bus.hs_addr] <= bus.hs_din;
  end

  // registered CPU and colour read data
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_dout_q <= 8'h00;
      color_q <= 8'h00;
    end else begin
      cpu_dout_q <= cpu_rd;
      color_q <= color_swz;
    end
  end

  // port B arbiter: video prefetch, hiscore grant, RAM sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_q <= 8'h00;
      hs_dout_q <= 8'h00;
      hs_ack_q <= 1'b0;
`ifdef INVADERS_RAM_CLEAR_EN
      state <= CLEAR;
      clr_addr <= '0;
      hold <= 1'b1;
`else
      state <= RUN_VID;
`endif
    end else begin
      hs_ack_q <= 1'b0;
      unique case (state)
        RUN_VID: begin
          vid_q <= ram[vid_rd_a];
          if (bus.hs_req && bus.vid_blank && !hs_ack_q)
            state <= HS_GRANT;
        end
        HS_GRANT: begin
          hs_dout_q <= ram[bus.hs_addr];
          hs_ack_q <= 1'b1;
          state <= RUN_VID;
        end
        CLEAR: begin
`ifdef INVADERS_RAM_CLEAR_EN
          clr_addr <= clr_addr + RAM_AW'(1);
          if (&clr_addr) begin
            state <= RUN_VID;
            hold <= 1'b0;
          end
`else
          state <= RUN_VID;
`endif
        end
        default: state <= RUN_VID;
      endcase
    end
  end

  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.cpu_hold  = hold;
  assign bus.vid_data  = vid_q;
  assign bus.color_out = color_q;
  assign bus.hs_dout   = hs_dout_q;
  assign bus.hs_ack    = hs_ack_q;
endmodule

// File: tb/tb_invaders_memmap.sv
// Bench for invaders_memmap: directed map/arbiter steps plus random CPU,
// colour and video traffic against a memory-map reference model.
module tb_invaders_memmap;
  localparam int RAW = 13;
  localparam int CAW = 11;
  localparam int NBANKS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  invaders_memmap_if #(.RAM_AW(RAW), .CRAM_AW(CAW)) bus();

  invaders_memmap #(
    .ROM_BANKS(NBANKS),
    .RAM_AW(RAW),
    .CRAM_AW(CAW),
    .PREFETCH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [7:0] m_rom [NBANKS][8192];
  logic [7:0] m_ram [8192];
  logic [7:0] m_cram [2048];

  int vectors = 0;
  int miscompares = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // colour-store index seen through the CPU window, -1 if none
  function automatic int cidx(input logic [15:0] a,
                              input int mode);
    int ai;
    ai = int'(a);
    if (mode == 1 && ai >= 'h5C00 && ai <= 'h5FFF)
      return ai - 'h5C00;
    if ((mode == 2 || mode == 3) &&
        ai >= 'hC000 && ai <= 'hDFFF)
      return ((ai / 256) % 64) * 32 + ai % 32;
    return -1;
  endfunction

  function automatic logic [7:0] ref_cpu(input logic [15:0] a,
                                         input int mode);
    int ai, c, b;
    ai = int'(a);
    c = cidx(a, mode);
    if (c >= 0) return m_cram[11'(c)];
    if (ai < 'h2000) return m_rom[0][13'(ai)];
    if (ai < 'h4000) return m_ram[13'(ai - 'h2000)];
    b = ai / 8192 - 1;
    if (b < NBANKS) return m_rom[1'(b)][13'(ai % 8192)];
    return 8'h00;
  endfunction

  function automatic logic [7:0] swz(input logic [7:0] v,
                                     input int mode);
    if (mode == 3) return ~v;
    if (mode == 4) return {v[7:3], v[1], v[2], v[0]};
    return v;
  endfunction

  task automatic rand_steps(input int n);
    for (int k = 0; k < n; k++) begin
      logic [15:0] a;
      logic [7:0] d, e_cpu, e_col, e_vid;
      logic [10:0] ca;
      logic [12:0] va;
      int mode, sel, c;
      logic wr;
      mode = $urandom_range(0, 4);
      sel = $urandom_range(0, 3);
      if (sel == 0)
        a = 16'h5C00 + 16'($urandom_range(0, 1023));
      else if (sel == 1)
        a = 16'hC000 + 16'($urandom_range(0, 8191));
      else
        a = 16'($urandom);
      d = 8'($urandom);
      wr = ($urandom_range(0, 3) == 0);
      ca = 11'($urandom);
      va = 13'($urandom);
      bus.cmode = 3'(mode);
      bus.cpu_addr = a;
      bus.cpu_din = d;
      bus.cpu_wr = wr;
      bus.color_addr = ca;
      bus.vid_addr = va;
      e_cpu = ref_cpu(a, mode);
      e_col = swz(m_cram[ca], mode);
      e_vid = m_ram[13'((int'(va) + 1) % 8192)];
      tick;
      if (wr) begin
        c = cidx(a, mode);
        if (c >= 0) m_cram[11'(c)] = d;
        else if (int'(a) >= 'h2000 && int'(a) < 'h4000)
          m_ram[13'(int'(a) - 'h2000)] = d;
      end
      bus.cpu_wr = 1'b0;
      chk("rand_cpu", 16'(bus.cpu_dout), 16'(e_cpu));
      chk("rand_color", 16'(bus.color_out), 16'(e_col));
      chk("rand_vid", 16'(bus.vid_data), 16'(e_vid));
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, acks;
    bus.cpu_addr = '0;
    bus.cpu_wr = 1'b0;
    bus.cpu_din = '0;
    bus.cmode = '0;
    bus.dn_addr = '0;
    bus.dn_data = '0;
    bus.dn_wr = 1'b0;
    bus.vid_addr = '0;
    bus.vid_blank = 1'b0;
    bus.color_addr = '0;
    bus.hs_req = 1'b0;
    bus.hs_we = 1'b0;
    bus.hs_addr = '0;
    bus.hs_din = '0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_cpu_dout", 16'(bus.cpu_dout), 16'h00);
    chk("rst_vid_data", 16'(bus.vid_data), 16'h00);
    chk("rst_hs_dout", 16'(bus.hs_dout), 16'h00);
    chk("rst_hs_ack", 16'(bus.hs_ack), 16'h0);
    chk("rst_color", 16'(bus.color_out), 16'h00);

`ifdef INVADERS_RAM_CLEAR_EN
    chk("rst_hold", 16'(bus.cpu_hold), 16'h1);
    n = 0;
    while (bus.cpu_hold && n < 20000) begin
      n++;
      tick;
    end
    chk("hold_cycles", 16'(n), 16'd8192);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.hs_req = 1'b1;
    bus.hs_addr = 13'h0055;
    bus.vid_blank = 1'b1;
    n = 0;
    acks = 0;
    while (bus.cpu_hold && n < 20000) begin
      if (bus.hs_ack) acks++;
      n++;
      tick;
    end
    chk("hold_restart", 16'(n), 16'd8192);
    chk("ack_in_clear", 16'(acks), 16'd0);
    lat = 0;
    while (!bus.hs_ack && lat < 10) begin
      lat++;
      tick;
    end
    chk("hs_lat_post_clear", 16'(lat), 16'd2);
    chk("hs_dout_cleared", 16'(bus.hs_dout), 16'h00);
    bus.hs_req = 1'b0;
    bus.vid_blank = 1'b0;
    tick;
    bus.cpu_addr = 16'h3FFF;
    tick;
    chk("clear_3fff", 16'(bus.cpu_dout), 16'h00);
`else
    chk("rst_hold", 16'(bus.cpu_hold), 16'h0);
`endif

    // fill work RAM, ROM banks and colour PROM
    for (int i = 0; i < 8192; i++) begin
      bus.cpu_addr = 16'(16'h2000 + i);
      bus.cpu_din = 8'($urandom);
      bus.cpu_wr = 1'b1;
      m_ram[13'(i)] = bus.cpu_din;
      tick;
    end
    bus.cpu_wr = 1'b0;
    for (int i = 0; i < NBANKS * 8192; i++) begin
      bus.dn_addr = 16'(i);
      bus.dn_data = 8'($urandom);
      bus.dn_wr = 1'b1;
      m_rom[1'(i / 8192)][13'(i % 8192)] = bus.dn_data;
      tick;
    end
    for (int i = 0; i < 2048; i++) begin
      bus.dn_addr = 16'(16'h4000 + i);
      bus.dn_data = 8'($urandom);
      bus.dn_wr = 1'b1;
      m_cram[11'(i)] = bus.dn_data;
      tick;
    end
    bus.dn_addr = 16'h2000;
    bus.dn_data = 8'hA5;
    m_rom[1][0] = 8'hA5;
    tick;
    bus.dn_wr = 1'b0;

    bus.cmode = 3'd0;
    bus.cpu_addr = 16'h4000;
    tick;
    chk("rom_bank1_4000", 16'(bus.cpu_dout), 16'hA5);
    bus.cpu_addr = 16'h6000;
    tick;
    chk("unmapped_6000", 16'(bus.cpu_dout), 16'h00);
    bus.cpu_addr = 16'h0123;
    tick;
    chk("rom_bank0", 16'(bus.cpu_dout), 16'(m_rom[0][13'h123]));

    // download beats a CPU colour write in the same cycle
    bus.cmode = 3'd1;
    bus.dn_addr = 16'h4005;
    bus.dn_data = 8'h11;
    bus.dn_wr = 1'b1;
    bus.cpu_addr = 16'h5C05;
    bus.cpu_din = 8'h22;
    bus.cpu_wr = 1'b1;
    tick;
    bus.dn_wr = 1'b0;
    bus.cpu_wr = 1'b0;
    m_cram[5] = 8'h11;
    bus.cmode = 3'd0;
    bus.color_addr = 11'd5;
    tick;
    chk("dn_priority", 16'(bus.color_out), 16'h11);

    bus.cmode = 3'd2;
    bus.cpu_addr = 16'hC105;
    bus.cpu_din = 8'h3C;
    bus.cpu_wr = 1'b1;
    tick;
    bus.cpu_wr = 1'b0;
    m_cram[37] = 8'h3C;
    bus.color_addr = 11'd37;
    tick;
    chk("cwin_mode2", 16'(bus.color_out), 16'h3C);
    chk("cwin_cpu_rd", 16'(bus.cpu_dout), 16'h3C);
    bus.cmode = 3'd3;
    tick;
    chk("cwin_mode3_inv", 16'(bus.color_out), 16'hC3);
    bus.cmode = 3'd4;
    tick;
    chk("mode4_swap", 16'(bus.color_out), 16'h3A);
    bus.cmode = 3'd0;

    bus.cpu_addr = 16'h2010;
    bus.cpu_din = 8'h77;
    bus.cpu_wr = 1'b1;
    tick;
    bus.cpu_wr = 1'b0;
    m_ram[13'h010] = 8'h77;
    tick;
    chk("ram_wr_then_rd", 16'(bus.cpu_dout), 16'h77);
    bus.cpu_addr = 16'h2101;
    bus.cpu_din = 8'h88;
    bus.cpu_wr = 1'b1;
    tick;
    bus.cpu_wr = 1'b0;
    m_ram[13'h101] = 8'h88;
    bus.vid_addr = 13'h1FFF;
    tick;
    chk("vid_wrap", 16'(bus.vid_data), 16'(m_ram[0]));

    // hiscore read held off by active video
    bus.hs_req = 1'b1;
    bus.hs_we = 1'b0;
    bus.hs_addr = 13'h0010;
    bus.vid_blank = 1'b0;
    bus.vid_addr = 13'h000F;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hs_wait_active", 16'(bus.hs_ack), 16'h0);
    end
    chk("vid_prefetch", 16'(bus.vid_data), 16'h77);
    bus.vid_blank = 1'b1;
    tick;
    chk("hs_ack_early", 16'(bus.hs_ack), 16'h0);
    bus.vid_addr = 13'h0100;
    tick;
    chk("hs_ack", 16'(bus.hs_ack), 16'h1);
    chk("hs_dout", 16'(bus.hs_dout), 16'h77);
    chk("vid_hold", 16'(bus.vid_data), 16'h77);
    bus.hs_req = 1'b0;
    tick;
    chk("hs_ack_pulse", 16'(bus.hs_ack), 16'h0);
    chk("vid_resume", 16'(bus.vid_data), 16'h88);

    // hiscore write collides with CPU write: hiscore wins
    bus.hs_req = 1'b1;
    bus.hs_we = 1'b1;
    bus.hs_addr = 13'h0200;
    bus.hs_din = 8'hB1;
    tick;
    bus.cpu_addr = 16'h2200;
    bus.cpu_din = 8'h4E;
    bus.cpu_wr = 1'b1;
    tick;
    chk("hs_wr_ack", 16'(bus.hs_ack), 16'h1);
    bus.cpu_wr = 1'b0;
    bus.hs_req = 1'b0;
    bus.hs_we = 1'b0;
    m_ram[13'h200] = 8'hB1;
    tick;
    chk("portb_wins", 16'(bus.cpu_dout), 16'hB1);

    for (int k = 0; k < 8; k++) begin
      logic we;
      logic [12:0] ha;
      logic [7:0] hd;
      we = 1'($urandom);
      ha = 13'($urandom);
      hd = 8'($urandom);
      bus.hs_req = 1'b1;
      bus.hs_we = we;
      bus.hs_addr = ha;
      bus.hs_din = hd;
      lat = 0;
      do begin
        tick;
        lat++;
      end while (!bus.hs_ack && lat < 10);
      chk("hs_rand_lat", 16'(lat), 16'd2);
      if (we) m_ram[ha] = hd;
      else chk("hs_rand_rd", 16'(bus.hs_dout), 16'(m_ram[ha]));
      bus.hs_req = 1'b0;
      bus.hs_we = 1'b0;
      tick;
    end

    rand_steps(300);

    // reset during a grant drops the ack; ROM/colour survive
    bus.hs_req = 1'b1;
    bus.hs_we = 1'b0;
    bus.vid_blank = 1'b1;
    tick;
    rst = 1'b1;
    bus.hs_req = 1'b0;
    tick;
    rst = 1'b0;
    chk("grant_rst_ack", 16'(bus.hs_ack), 16'h0);
    tick;
    chk("grant_rst_ack2", 16'(bus.hs_ack), 16'h0);
`ifdef INVADERS_RAM_CLEAR_EN
    n = 0;
    while (bus.cpu_hold && n < 20000) begin
      n++;
      tick;
    end
    chk("hold_rearm", 16'(n), 16'd8191);
    for (int i = 0; i < 8192; i++) m_ram[13'(i)] = 8'h00;
`endif
    rand_steps(150);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
